// File: rtl/soc_timer_bank.sv
// soc_timer_bank: shared 64-bit mtime with prescaler plus NUM_CH 64-bit
// compare channels (one-shot or periodic auto-reload), sticky W1C pending
// bits, per-channel interrupt enables and a combined interrupt line.
// Register bus is the single-cycle req/we/addr/be/wdata/rdata style.
module soc_timer_bank #(
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_reg_req,
  input  logic              i_reg_we,
  input  logic [ADDR_W-1:0] i_reg_addr,
  input  logic [7:0]        i_reg_be,
  input  logic [63:0]       i_reg_wdata,
  output logic [63:0]       o_reg_rdata,
  output logic [NUM_CH-1:0] o_irq,
  output logic              o_irq_any
);

  // Expand byte enables into a 64-bit bit mask.
  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    m = 64'd0;
    for (int b = 0; b < 8; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  // Byte-wise merge: enabled bytes come from the write, the rest keep old_v.
  function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic [7:0]  be);
    return (old_v & ~be_mask(be)) | (new_v & be_mask(be));
  endfunction

  // 64-bit image of a channel control register.
  function automatic logic [63:0] chctl_img(input logic en, input logic per,
                                            input logic [31:0] period);
    return {period, 30'd0, per, en};
  endfunction

  logic [63:0]           mtime_q, mtime_d;
  logic                  run_q, run_d;
  logic [PRESCALE_W-1:0] div_q, div_d, presc_q, presc_d;
  logic [NUM_CH-1:0]     pend_q, pend_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]     en_q, en_d, per_q, per_d;
  logic [63:0]           cmp_q [NUM_CH];
  logic [63:0]           cmp_d [NUM_CH];
  logic [31:0]           period_q [NUM_CH];
  logic [31:0]           period_d [NUM_CH];
  logic [63:0]           rdata_q, rdata_d;

  logic                  wr_s, rd_s, tick_s;
  logic [ADDR_W-1:0]     word_addr_s;
  logic                  sel_mtime_s, sel_ctrl_s, sel_irq_s;
  logic [NUM_CH-1:0]     sel_cmp_s, sel_chctl_s, hit_s, clr_s;
  logic [63:0]           ctrl_img_s, ctrl_m_s, irq_img_s, irq_m_s, wmask_s, rd_val_s;
  logic [63:0]           cmp_hw_s [NUM_CH];
  logic [63:0]           chctl_m_s [NUM_CH];
  logic [NUM_CH-1:0]     en_hw_s;

  assign wr_s        = i_reg_req & i_reg_we;
  assign rd_s        = i_reg_req & ~i_reg_we;
  assign word_addr_s = i_reg_addr & ~ADDR_W'(7);
  assign wmask_s     = i_reg_wdata & be_mask(i_reg_be);

  // Address decode; low three address bits are ignored.
  always_comb begin
    sel_mtime_s = (word_addr_s == ADDR_W'(0));
    sel_ctrl_s  = (word_addr_s == ADDR_W'(8));
    sel_irq_s   = (word_addr_s == ADDR_W'(16));
    for (int n = 0; n < NUM_CH; n++) begin
      sel_cmp_s[n]   = (word_addr_s == ADDR_W'(128 + 16*n));
      sel_chctl_s[n] = (word_addr_s == ADDR_W'(136 + 16*n));
    end
  end

  // Prescaler and mtime; a software MTIME write beats a tick on the same edge.
  always_comb begin
    tick_s = run_q && (presc_q == div_q);
    if (wr_s && sel_ctrl_s) begin
      presc_d = '0;
    end else if (!run_q || tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESCALE_W'(1);
    end
    if (wr_s && sel_mtime_s) begin
      mtime_d = be_merge(mtime_q, i_reg_wdata, i_reg_be);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  // CTRL and IRQ registers; a hardware pending set wins over a same-cycle W1C.
  always_comb begin
    ctrl_img_s                   = 64'd0;
    ctrl_img_s[0]                = run_q;
    ctrl_img_s[16 +: PRESCALE_W] = div_q;
    ctrl_m_s = (wr_s && sel_ctrl_s) ? be_merge(ctrl_img_s, i_reg_wdata, i_reg_be) : ctrl_img_s;
    run_d    = ctrl_m_s[0];
    div_d    = ctrl_m_s[16 +: PRESCALE_W];

    irq_img_s               = 64'd0;
    irq_img_s[0 +: NUM_CH]  = pend_q;
    irq_img_s[32 +: NUM_CH] = irq_en_q;
    irq_m_s  = (wr_s && sel_irq_s) ? be_merge(irq_img_s, i_reg_wdata, i_reg_be) : irq_img_s;
    irq_en_d = irq_m_s[32 +: NUM_CH];
    clr_s    = (wr_s && sel_irq_s) ? wmask_s[NUM_CH-1:0] : {NUM_CH{1'b0}};
    pend_d   = (pend_q & ~clr_s) | hit_s;
  end

  // Compare channels: hardware reload/EN-clear first, then written bytes override.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      hit_s[n]     = en_q[n] && (mtime_q >= cmp_q[n]);
      cmp_hw_s[n]  = (hit_s[n] && per_q[n]) ? (cmp_q[n] + {32'd0, period_q[n]}) : cmp_q[n];
      en_hw_s[n]   = (hit_s[n] && !per_q[n]) ? 1'b0 : en_q[n];
      cmp_d[n]     = (wr_s && sel_cmp_s[n]) ? be_merge(cmp_hw_s[n], i_reg_wdata, i_reg_be)
                                            : cmp_hw_s[n];
      chctl_m_s[n] = (wr_s && sel_chctl_s[n])
                     ? be_merge(chctl_img(en_hw_s[n], per_q[n], period_q[n]), i_reg_wdata, i_reg_be)
                     : chctl_img(en_hw_s[n], per_q[n], period_q[n]);
      en_d[n]      = chctl_m_s[n][0];
      per_d[n]     = chctl_m_s[n][1];
      period_d[n]  = chctl_m_s[n][63:32];
    end
  end

  // Read mux; unmapped addresses return zero and rdata only moves on reads.
  always_comb begin
    rd_val_s = ({64{sel_mtime_s}} & mtime_q)
             | ({64{sel_ctrl_s}}  & ctrl_img_s)
             | ({64{sel_irq_s}}   & irq_img_s);
    for (int n = 0; n < NUM_CH; n++) begin
      rd_val_s = rd_val_s
               | ({64{sel_cmp_s[n]}}   & cmp_q[n])
               | ({64{sel_chctl_s[n]}} & chctl_img(en_q[n], per_q[n], period_q[n]));
    end
    rdata_d = rd_s ? rd_val_s : rdata_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q  <= 64'd0;
      run_q    <= 1'b0;
      div_q    <= '0;
      presc_q  <= '0;
      pend_q   <= '0;
      irq_en_q <= '0;
      en_q     <= '0;
      per_q    <= '0;
      rdata_q  <= 64'd0;
      for (int n = 0; n < NUM_CH; n++) begin
        cmp_q[n]    <= {64{1'b1}};
        period_q[n] <= 32'd0;
      end
    end else begin
      mtime_q  <= mtime_d;
      run_q    <= run_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      pend_q   <= pend_d;
      irq_en_q <= irq_en_d;
      en_q     <= en_d;
      per_q    <= per_d;
      rdata_q  <= rdata_d;
      for (int n = 0; n < NUM_CH; n++) begin
        cmp_q[n]    <= cmp_d[n];
        period_q[n] <= period_d[n];
      end
    end
  end

  assign o_reg_rdata = rdata_q;
  assign o_irq       = pend_q & irq_en_q;
  assign o_irq_any   = |o_irq;

endmodule

// File: tb/tb_soc_timer_bank.sv
// Directed testbench for soc_timer_bank: register table plus timed sequences.
module tb_soc_timer_bank;

  localparam int NUM_CH = 4;

  logic              clk;
  logic              rst_n;
  logic              i_reg_req;
  logic              i_reg_we;
  logic [7:0]        i_reg_addr;
  logic [7:0]        i_reg_be;
  logic [63:0]       i_reg_wdata;
  logic [63:0]       o_reg_rdata;
  logic [NUM_CH-1:0] o_irq;
  logic              o_irq_any;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  soc_timer_bank #(.NUM_CH(NUM_CH), .PRESCALE_W(16), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_reg_req  (i_reg_req),
    .i_reg_we   (i_reg_we),
    .i_reg_addr (i_reg_addr),
    .i_reg_be   (i_reg_be),
    .i_reg_wdata(i_reg_wdata),
    .o_reg_rdata(o_reg_rdata),
    .o_irq      (o_irq),
    .o_irq_any  (o_irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vec [36];

  function automatic vec_t rv(input logic [7:0] addr, input logic [63:0] exp);
    vec_t v;
    v.we = 1'b0; v.addr = addr; v.be = 8'h00; v.wdata = 64'd0; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t wv(input logic [7:0] addr, input logic [7:0] be, input logic [63:0] d);
    vec_t v;
    v.we = 1'b1; v.addr = addr; v.be = be; v.wdata = d; v.exp = 64'd0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks are entered just after a falling edge and return after the next one.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] be, input logic [63:0] d);
    i_reg_req = 1'b1; i_reg_we = 1'b1; i_reg_addr = addr; i_reg_be = be; i_reg_wdata = d;
    @(negedge clk);
    i_reg_req = 1'b0; i_reg_we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [63:0] d);
    i_reg_req = 1'b1; i_reg_we = 1'b0; i_reg_addr = addr; i_reg_be = 8'h00;
    @(negedge clk);
    i_reg_req = 1'b0;
    d = o_reg_rdata;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic wait_irq(input int b, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (o_irq[b]) begin
        at = cyc;
        break;
      end
    end
  endtask

  logic [63:0] rd;
  int s, at;

  initial begin
    rst_n = 1'b0; i_reg_req = 1'b0; i_reg_we = 1'b0;
    i_reg_addr = 8'h00; i_reg_be = 8'h00; i_reg_wdata = 64'd0;
    idle(3);
    rst_n = 1'b1;

    // Scribble registers and let things run, then reset with a write in flight.
    do_write(8'h00, 8'hFF, 64'd123);
    do_write(8'h10, 8'hFF, 64'h0000_000F_0000_000F);
    do_write(8'h80, 8'hFF, 64'd130);
    do_write(8'h88, 8'hFF, 64'h0000_0005_0000_0003);
    do_write(8'hB0, 8'hFF, 64'd7);
    do_write(8'h08, 8'hFF, 64'h0000_0000_0005_0001);
    idle(30);
    rst_n = 1'b0;
    do_write(8'h00, 8'hFF, 64'h1234);
    idle(1);
    rst_n = 1'b1;
    check("rst_rdata", o_reg_rdata, 64'd0);
    check("rst_irq", {59'd0, o_irq_any, o_irq}, 64'd0);

    vec[0]  = rv(8'h00, 64'd0);
    vec[1]  = rv(8'h08, 64'd0);
    vec[2]  = rv(8'h10, 64'd0);
    vec[3]  = rv(8'h80, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[4]  = rv(8'h90, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[5]  = rv(8'hA0, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[6]  = rv(8'hB0, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[7]  = rv(8'h88, 64'd0);
    vec[8]  = rv(8'h98, 64'd0);
    vec[9]  = rv(8'hA8, 64'd0);
    vec[10] = rv(8'hB8, 64'd0);
    vec[11] = wv(8'h08, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    vec[12] = rv(8'h08, 64'h0000_0000_FFFF_0000);
    vec[13] = rv(8'h0B, 64'h0000_0000_FFFF_0000);
    vec[14] = wv(8'h00, 8'h0F, 64'h1122_3344_5566_7788);
    vec[15] = rv(8'h00, 64'h0000_0000_5566_7788);
    vec[16] = wv(8'h00, 8'hF0, 64'hAAAA_AAAA_AAAA_AAAA);
    vec[17] = rv(8'h00, 64'hAAAA_AAAA_5566_7788);
    vec[18] = wv(8'h90, 8'h01, 64'd0);
    vec[19] = rv(8'h90, 64'hFFFF_FFFF_FFFF_FF00);
    vec[20] = wv(8'hA8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFC);
    vec[21] = rv(8'hA8, 64'hFFFF_FFFF_0000_0000);
    vec[22] = wv(8'h10, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[23] = rv(8'h10, 64'h0000_000F_0000_0000);
    vec[24] = wv(8'hC0, 8'hFF, 64'd5);
    vec[25] = rv(8'hC0, 64'd0);
    vec[26] = rv(8'hC8, 64'd0);
    vec[27] = rv(8'h18, 64'd0);
    vec[28] = rv(8'h48, 64'd0);
    vec[29] = wv(8'h10, 8'hF0, 64'd0);
    vec[30] = wv(8'h90, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[31] = wv(8'hA8, 8'hFF, 64'd0);
    vec[32] = wv(8'h08, 8'hFF, 64'd0);
    vec[33] = wv(8'h00, 8'hFF, 64'd0);
    vec[34] = rv(8'h10, 64'd0);
    vec[35] = rv(8'h90, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 36; i++) begin
      if (vec[i].we) begin
        do_write(vec[i].addr, vec[i].be, vec[i].wdata);
      end else begin
        do_read(vec[i].addr, rd);
        check($sformatf("vec[%0d]@%h", i, vec[i].addr), rd, vec[i].exp);
      end
    end

    // One-shot channel 0 at CMP=10, DIV=0: pending appears when mtime is 11.
    do_write(8'h80, 8'hFF, 64'd10);
    do_write(8'h88, 8'hFF, 64'h1);
    do_write(8'h10, 8'hF0, 64'h0000_0001_0000_0000);
    do_write(8'h08, 8'hFF, 64'h1);
    s = cyc;
    wait_irq(0, 40, at);
    check("oneshot_rise", 64'(at - s), 64'd11);
    check("oneshot_any", {63'd0, o_irq_any}, 64'd1);
    do_read(8'h88, rd);
    check("oneshot_en_clr", rd, 64'd0);
    do_read(8'h10, rd);
    check("oneshot_pend", rd, 64'h0000_0001_0000_0001);
    do_write(8'h10, 8'h01, 64'h1);
    check("oneshot_w1c", {59'd0, o_irq_any, o_irq}, 64'd0);

    // Prescaler DIV=3: one tick per four cycles.
    do_write(8'h08, 8'hFF, 64'd0);
    do_write(8'h00, 8'hFF, 64'd0);
    do_write(8'h08, 8'hFF, 64'h0000_0000_0003_0001);
    idle(40);
    do_read(8'h00, rd);
    check("div3_mtime", rd, 64'd10);

    // Periodic channel 1: CMP=100, PERIOD=50.
    do_write(8'h08, 8'hFF, 64'd0);
    do_write(8'h00, 8'hFF, 64'd0);
    do_write(8'h90, 8'hFF, 64'd100);
    do_write(8'h98, 8'hFF, 64'h0000_0032_0000_0003);
    do_write(8'h10, 8'hF0, 64'h0000_0003_0000_0000);
    do_write(8'h08, 8'hFF, 64'h1);
    s = cyc;
    for (int h = 0; h < 3; h++) begin
      wait_irq(1, 120, at);
      check($sformatf("per_rise%0d", h), 64'(at - s), 64'(101 + 50*h));
      do_read(8'h90, rd);
      check($sformatf("per_cmp%0d", h), rd, 64'(150 + 50*h));
      do_write(8'h10, 8'h01, 64'h2);
      check($sformatf("per_w1c%0d", h), 64'(o_irq), 64'd0);
    end

    // Same-cycle W1C versus a hit on channel 2 (PERIOD=0 hits every cycle).
    do_write(8'h08, 8'hFF, 64'd0);
    do_write(8'h98, 8'hFF, 64'd0);
    do_write(8'h10, 8'hFF, 64'h0000_0004_0000_00FF);
    do_write(8'h00, 8'hFF, 64'd500);
    do_write(8'hA0, 8'hFF, 64'd100);
    do_write(8'hA8, 8'hFF, 64'h3);
    idle(1);
    check("w1c_pre", 64'(o_irq), 64'h4);
    do_write(8'h10, 8'h01, 64'h4);
    check("w1c_set_wins", 64'(o_irq), 64'h4);
    do_read(8'h10, rd);
    check("w1c_irq_reg", rd, 64'h0000_0004_0000_0004);
    do_write(8'hA8, 8'hFF, 64'd0);
    do_write(8'h10, 8'h01, 64'h4);
    do_read(8'h10, rd);
    check("w1c_cleared", rd, 64'h0000_0004_0000_0000);
    check("w1c_any", {63'd0, o_irq_any}, 64'd0);

    // mtime wrap with DIV=0.
    do_write(8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    do_write(8'h08, 8'hFF, 64'h1);
    do_read(8'h00, rd);
    check("wrap_t0", rd, 64'hFFFF_FFFF_FFFF_FFFE);
    do_read(8'h00, rd);
    check("wrap_t1", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(8'h00, rd);
    check("wrap_t2", rd, 64'd0);
    do_write(8'h08, 8'hFF, 64'd0);

    // Periodic reload wraps on channel 3: exactly one hit, then EN written off.
    do_write(8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFF0);
    do_write(8'hB0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFF0);
    do_write(8'h10, 8'hF0, 64'h0000_0008_0000_0000);
    do_write(8'hB8, 8'hFF, 64'h0000_0020_0000_0003);
    do_write(8'hB8, 8'hFF, 64'h0000_0020_0000_0002);
    do_read(8'hB0, rd);
    check("reload_wrap_cmp", rd, 64'h10);
    do_read(8'hB8, rd);
    check("reload_chctl", rd, 64'h0000_0020_0000_0002);
    do_read(8'h10, rd);
    check("reload_pend", rd, 64'h0000_0008_0000_0008);
    do_write(8'h08, 8'hFF, 64'd0);
    check("rdata_hold_on_write", o_reg_rdata, 64'h0000_0008_0000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
